// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between a memory controller and the backing-memory responder.
interface mem_responder_if #(
  parameter int WORD_SIZE = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_wr;
  logic [WORD_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0] req_data;
  logic                 resp_valid;
  logic                 resp_ready;
  logic                 resp_wr;
  logic [WORD_SIZE-1:0] resp_data;

  modport master (
    output req_valid, req_wr, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_wr, resp_data
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_wr, resp_data
  );
endinterface

// File: rtl/mem_responder.sv
// Backing-memory responder: single outstanding word request, fixed access latency,
// storage cleared word-by-word after every reset.
module mem_responder #(
  parameter int WORD_SIZE = 32,
  parameter int MEM_DEPTH = 256,
  parameter int MEM_DELAY = 3
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   bus,
  output logic             busy
);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(MEM_DELAY + 1);

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] mem [MEM_DEPTH];
  logic [IW-1:0]        ptr, cap_idx, req_idx, src_idx;
  logic [CW-1:0]        cnt;
  logic                 cap_wr, src_wr, resp_wr_q, accept, resp_load;
  logic [WORD_SIZE-1:0] cap_data, src_data, resp_data_q;
  logic                 unused_addr;

  assign req_idx     = bus.req_addr[2 +: IW];
  assign unused_addr = ^bus.req_addr;

  // With a one-cycle delay RESP is entered straight from IDLE, before the capture
  // registers hold the request, so the response is sourced from the live inputs.
  assign src_wr   = (state == IDLE) ? bus.req_wr   : cap_wr;
  assign src_idx  = (state == IDLE) ? req_idx      : cap_idx;
  assign src_data = (state == IDLE) ? bus.req_data : cap_data;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      INIT: if (ptr == IW'(MEM_DEPTH - 1)) state_nxt = IDLE;
      IDLE: if (bus.req_valid) begin
        accept    = 1'b1;
        state_nxt = (MEM_DELAY == 1) ? RESP : WAIT;
      end
      WAIT: if (cnt == CW'(1)) state_nxt = RESP;
      RESP: if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
    resp_load = (state != RESP) && (state_nxt == RESP);

    // Outputs are forced quiet while reset is low, whatever state is still registered.
    bus.req_ready  = rst && (state == IDLE);
    bus.resp_valid = rst && (state == RESP);
    bus.resp_wr    = rst && resp_wr_q;
    bus.resp_data  = rst ? resp_data_q : '0;
    busy           = !rst || (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= INIT;
      ptr         <= '0;
      cnt         <= '0;
      cap_wr      <= 1'b0;
      cap_idx     <= '0;
      cap_data    <= '0;
      resp_wr_q   <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) ptr <= ptr + 1'b1;
      if (accept) begin
        cap_wr   <= bus.req_wr;
        cap_idx  <= req_idx;
        cap_data <= bus.req_data;
        cnt      <= CW'(MEM_DELAY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end
      if (resp_load) begin
        resp_wr_q   <= src_wr;
        resp_data_q <= src_wr ? src_data : mem[src_idx];
      end
    end
  end

  // Storage has no reset; INIT clears it, and a reset edge never commits a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == INIT)            mem[ptr]     <= '0;
      else if (resp_load && src_wr) mem[src_idx] <= src_data;
    end
  end
endmodule
